// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and elaboration helpers for the sequential divider
//
// Holds the divider FSM state enum, the iteration-counter width helper and
// the legal quotient-bits-per-cycle check used by div_seq_multi.
package div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Counter must hold LEN/STEP itself, hence the +1.
   function automatic int cnt_width(input int len, input int step);
      return $clog2(len / step + 1);
   endfunction

   function automatic bit step_ok(input int step);
      return (step == 1) || (step == 2) || (step == 4);
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - combinational STEP-bit restoring division stage
//
// Ports:
//   rem_i  : partial remainder entering the stage (always < div_i)
//   bits_i : next STEP dividend bits, MSB first
//   div_i  : divisor magnitude (non-zero)
//   rem_o  : partial remainder leaving the stage
//   q_o    : STEP quotient bits produced, MSB first
module div_step
   import div_pkg::*;
#(
   parameter int LEN  = 16,
   parameter int STEP = 1
) (
   input  logic [LEN-1:0]  rem_i,
   input  logic [STEP-1:0] bits_i,
   input  logic [LEN-1:0]  div_i,
   output logic [LEN-1:0]  rem_o,
   output logic [STEP-1:0] q_o
);

   always_comb begin
      logic [LEN:0]   trial;
      logic [LEN-1:0] acc;
      acc   = rem_i;
      trial = '0;
      q_o   = '0;
      // acc < div_i on entry, so the shifted trial fits in LEN+1 bits and
      // the restored/subtracted value fits back into LEN bits.
      for (int i = STEP - 1; i >= 0; i--) begin
         trial = {acc, bits_i[i]};
         if (trial >= {1'b0, div_i}) begin
            trial  = trial - {1'b0, div_i};
            q_o[i] = 1'b1;
         end
         acc = trial[LEN-1:0];
      end
      rem_o = acc;
   end

endmodule

// File: rtl/div_seq_multi.sv
// rtl/div_seq_multi.sv - signed/unsigned sequential divider, STEP quotient bits per cycle
//
// Ports:
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   START      : launch; samples A, B, SIGNED; restarts if already busy
//   SIGNED     : 1 = two's-complement operands, 0 = unsigned
//   A, B       : dividend, divisor
//   BUSY       : operation in flight
//   DONE       : result valid, held until next START or reset
//   Q, R       : quotient, remainder (held until the next result)
//   DZ, OVF    : last result was divide-by-zero / signed MIN / -1
module div_seq_multi
   import div_pkg::*;
#(
   parameter int LEN  = 16,
   parameter int STEP = 1
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           START,
   input  logic           SIGNED,
   input  logic [LEN-1:0] A,
   input  logic [LEN-1:0] B,
   output logic           BUSY,
   output logic           DONE,
   output logic [LEN-1:0] Q,
   output logic [LEN-1:0] R,
   output logic           DZ,
   output logic           OVF
);

   localparam int NSTEPS = LEN / STEP;
   localparam int CW     = cnt_width(LEN, STEP);
   localparam logic [LEN-1:0] MIN_VAL = {1'b1, {(LEN-1){1'b0}}};

   if (!step_ok(STEP) || (LEN % STEP) != 0 || LEN < 2) begin : g_bad_cfg
      $error("div_seq_multi: illegal LEN/STEP combination");
   end

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [LEN-1:0] dvd_q;   // dividend bits still to retire, quotient shifts in at the bottom
   logic [LEN-1:0] rem_q;   // partial remainder
   logic [LEN-1:0] dsr_q;   // divisor magnitude
   logic [LEN-1:0] a_q;     // original operands, needed by the fix-up stage
   logic [LEN-1:0] b_q;
   logic           sgn_q;

   logic           busy_q, done_q, dz_q, ovf_q;
   logic [LEN-1:0] quo_q, rmd_q;

   logic [LEN-1:0] a_mag, b_mag;
   logic [LEN-1:0] rem_nxt;
   logic [STEP-1:0] q_bits;

   logic [LEN-1:0] quo_d, rmd_d;
   logic           dz_d, ovf_d;

   // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(LEN-1).
   assign a_mag = (SIGNED && A[LEN-1]) ? -A : A;
   assign b_mag = (SIGNED && B[LEN-1]) ? -B : B;

   div_step #(
      .LEN  (LEN),
      .STEP (STEP)
   ) u_step (
      .rem_i  (rem_q),
      .bits_i (dvd_q[LEN-1 -: STEP]),
      .div_i  (dsr_q),
      .rem_o  (rem_nxt),
      .q_o    (q_bits)
   );

   // Fix-up: special cases first, then sign restoration of the magnitudes.
   always_comb begin
      logic neg_q, neg_r;
      neg_q = sgn_q && (a_q[LEN-1] ^ b_q[LEN-1]);
      neg_r = sgn_q && a_q[LEN-1];
      dz_d  = (b_q == '0);
      ovf_d = sgn_q && (a_q == MIN_VAL) && (b_q == '1);
      quo_d = neg_q ? -dvd_q : dvd_q;
      rmd_d = neg_r ? -rem_q : rem_q;
      if (dz_d) begin
         quo_d = '1;
         rmd_d = a_q;
      end else if (ovf_d) begin
         quo_d = a_q;
         rmd_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         dsr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
      end else if (START) begin
         a_q     <= A;
         b_q     <= B;
         sgn_q   <= SIGNED;
         dvd_q   <= a_mag;
         dsr_q   <= b_mag;
         rem_q   <= '0;
         cnt_q   <= CW'(NSTEPS);
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         state_q <= (B == '0) ? ST_FIX : ST_CALC;
      end else begin
         case (state_q)
            ST_CALC: begin
               rem_q <= rem_nxt;
               dvd_q <= (dvd_q << STEP) | LEN'(q_bits);
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               quo_q   <= quo_d;
               rmd_q   <= rmd_d;
               dz_q    <= dz_d;
               ovf_q   <= ovf_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            default: state_q <= state_q;
         endcase
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign Q    = quo_q;
   assign R    = rmd_q;
   assign DZ   = dz_q;
   assign OVF  = ovf_q;

endmodule

// File: doc/div_seq_multi.md
# div_seq_multi

Parametrised sequential divider, the next generation of the single-mode unsigned sequential divider. Adds signed/unsigned mode per operation and configurable quotient bits per cycle (radix 2^STEP). Adds explicit BUSY, divide-by-zero and signed-overflow flags, plus asynchronous active-low reset. It sits behind the ALU issue logic as a multi-cycle execution unit, with a START/DONE handshake.

## Interface
- LEN, 16, operand/result width in bits; ≥ 2.
- STEP, 1, quotient bits retired per cycle; 1, 2 or 4; LEN % STEP == 0 (elaboration error otherwise).
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  launch; samples A, B, SIGNED on the same edge.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned.
- A  input  LEN  dividend.
- B  input  LEN  divisor.
- BUSY  output  1  operation in flight.
- DONE  output  1  result valid; level, held until next START or reset.
- Q  output  LEN  quotient.
- R  output  LEN  remainder.
- DZ  output  1  last result was divide-by-zero.
- OVF  output  1  last result was signed overflow (MIN / -1).

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE; BUSY, DONE, Q, R, DZ and OVF are all 0.
- START in any state: latch operands, clear DONE/DZ/OVF, set BUSY.
  - If B == 0: go to FIX.
  - Otherwise: go to CALC with the counter at LEN/STEP.
  - START while busy aborts the current operation and restarts; no result is produced for the aborted one.
- Signed mode: the magnitudes |A| and |B| are used inside CALC.
  - Quotient is negated if sign(A) ≠ sign(B); it truncates toward zero.
  - Remainder is negated if A < 0; its sign follows the dividend.
- CALC: restoring division, STEP quotient bits per edge, MSB first. Decrement the counter; at 0, go to FIX.
- FIX: apply sign correction and the special cases, drive Q/R, then go to DONE. In DONE: BUSY=0, DONE=1.
- Divide-by-zero (both modes): Q = all ones, R = A, DZ = 1.
- Signed overflow (A = 2^(LEN-1), B = all ones, SIGNED=1): Q = A, R = 0, OVF = 1.
- Q/R are held from the FIX edge until the next FIX. They remain readable after DONE drops on a new START.
- RST_N low at any time: immediate return to reset values; an in-flight operation is discarded.

## Timing
- Edge 0: START sampled. Normal path gives DONE=1 after edge LEN/STEP + 1, i.e. LEN/STEP + 2 edges inclusive.
  - LEN=16, STEP=1: 18 edges. STEP=4: 6 edges.
- B == 0 path: DONE after edge 1 (2 edges).
- BUSY=1 from after edge 0 until the edge that sets DONE.
- No combinational path from inputs to outputs; all outputs are registered.
- START held high continuously restarts every edge; DONE never asserts.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the counter-width function clog2(LEN/STEP + 1);
  - the allowed-STEP check.
- Sub-module div_step: combinational STEP-bit restoring stage.
  - Inputs: partial remainder, shifted-in dividend bits, divisor.
  - Outputs: next partial remainder, STEP quotient bits.
  - Instantiated once in the top.
- The top holds the FSM, counter, operand/sign registers and the fix-up mux.

## Test plan
- LEN=16, STEP=1, unsigned: A=0x0064, B=0x0007 → Q=0x000E, R=0x0002, DZ=0, OVF=0, DONE at edge 17. Then A=0xFFFF, B=0x0001 → Q=0xFFFF, R=0.
- Signed, STEP=2: A=0xFFF9 (-7), B=0x0002 → Q=0xFFFD (-3), R=0xFFFF (-1). Then A=0x0007, B=0xFFFE → Q=0xFFFD, R=0x0001.
- Divide-by-zero: A=0x1234, B=0, both modes → Q=0xFFFF, R=0x1234, DZ=1, DONE after 2 edges.
- Overflow: SIGNED=1, A=0x8000, B=0xFFFF → Q=0x8000, R=0, OVF=1. Same operands with SIGNED=0 → Q=0, R=0x8000, OVF=0.
- Abort/reset: START mid-CALC with new operands → only the new result appears, with full latency from the second START. RST_N low mid-CALC → all outputs 0 immediately, and the FSM stays IDLE until START.
- Random sweep: 1000 operand pairs × {STEP=1,2,4} × {SIGNED=0,1} compared against a reference model, including latency and the BUSY/DONE exclusivity check.
